// File: rtl/doublebuffer_ctrl_pkg.sv
// doublebuffer_ctrl_pkg: shared FSM encoding, bank select and default block size
package doublebuffer_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEND, S_FILL_NEXT, S_WAIT_SUM, S_DRAIN, S_FINISH
  } state_t;
  localparam int SIZE_M1 = 16383;
  function automatic logic bank_sel(input int unsigned k);
    return 1'(k % 2);
  endfunction
endpackage

// File: rtl/doublebuffer_skid.sv
// doublebuffer_skid: 2-entry valid/ready FIFO absorbing the drain memory latency
module doublebuffer_skid #(
  parameter int W_D = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           i_valid,
  input  logic [W_D-1:0] i_data,
  output logic           o_valid,
  output logic [W_D-1:0] o_data,
  input  logic           i_ready,
  output logic [1:0]     o_cnt
);
  logic [W_D-1:0] r_mem [2];
  logic           r_wp, r_rp;
  logic [1:0]     r_cnt;
  logic           w_push, w_pop;
  assign w_pop   = o_valid && i_ready;
  assign w_push  = i_valid && (r_cnt != 2'd2 || w_pop);
  assign o_valid = r_cnt != 2'd0;
  assign o_data  = r_mem[r_rp];
  assign o_cnt   = r_cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: rtl/doublebuffer_ctrl.sv
// doublebuffer_ctrl: ping-pong fill/drain controller for the double-buffered prefix-sum user logic
module doublebuffer_ctrl
  import doublebuffer_ctrl_pkg::*;
#(
  parameter int W_A  = 14,
  parameter int W_D  = 32,
  parameter int SIZE = SIZE_M1 + 1,
  parameter int W_NB = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic [W_NB-1:0] num_blocks,
  output logic            busy,
  output logic            done,
  output logic [W_D-1:0]  last_sum,
  input  logic [W_D-1:0]  src_data,
  input  logic            src_valid,
  output logic            src_ready,
  output logic [W_A-1:0]  fill_addr,
  output logic [W_D-1:0]  fill_d,
  output logic            fill_we0,
  output logic            fill_we1,
  output logic [W_A-1:0]  drain_addr,
  input  logic [W_D-1:0]  drain_q0,
  input  logic [W_D-1:0]  drain_q1,
  output logic [W_D-1:0]  dst_data,
  output logic            dst_valid,
  input  logic            dst_ready,
  output logic [W_D-1:0]  chan_d,
  output logic            chan_enq,
  input  logic            chan_full,
  input  logic [W_D-1:0]  chan_q,
  output logic            chan_deq,
  input  logic            chan_empty
);
  localparam logic [W_A-1:0] LAST = W_A'(SIZE - 1);
  state_t          r_state;
  logic [W_NB-1:0] r_k, r_nb;
  logic [W_A-1:0]  r_addr, r_rd_addr, r_out_addr, r_fill_addr;
  logic [W_D-1:0]  r_fill_d, r_chan_d, r_last_sum;
  logic            r_busy, r_done, r_we0, r_we1, r_chan_enq, r_chan_deq;
  logic            r_inflight, r_all_issued;
  logic            w_fill_hs, w_bank, w_pop, w_issue, w_more;
  logic [1:0]      w_cnt;
  logic [W_D-1:0]  w_drain_q;
  assign src_ready  = r_state == S_FILL || r_state == S_FILL_NEXT;
  assign w_fill_hs  = src_ready && src_valid;
  assign w_bank     = bank_sel(32'(r_k) + 32'(r_state == S_FILL_NEXT));
  assign w_more     = {1'b0, r_k} + (W_NB+1)'(1) < {1'b0, r_nb};
  assign w_pop      = dst_valid && dst_ready;
  // Read only when the skid FIFO is guaranteed room for the word already in flight.
  assign w_issue    = r_state == S_DRAIN && !r_all_issued &&
                      (3'(w_cnt) + 3'(r_inflight) - 3'(w_pop)) < 3'd2;
  assign w_drain_q  = bank_sel(32'(r_k)) ? drain_q1 : drain_q0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign last_sum   = r_last_sum;
  assign fill_addr  = r_fill_addr;
  assign fill_d     = r_fill_d;
  assign fill_we0   = r_we0;
  assign fill_we1   = r_we1;
  assign drain_addr = r_rd_addr;
  assign chan_d     = r_chan_d;
  assign chan_enq   = r_chan_enq;
  assign chan_deq   = r_chan_deq;
  doublebuffer_skid #(.W_D(W_D)) u_skid (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_valid(r_inflight),
    .i_data (w_drain_q),
    .o_valid(dst_valid),
    .o_data (dst_data),
    .i_ready(dst_ready),
    .o_cnt  (w_cnt)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_nb         <= '0;
      r_addr       <= '0;
      r_rd_addr    <= '0;
      r_out_addr   <= '0;
      r_fill_addr  <= '0;
      r_fill_d     <= '0;
      r_chan_d     <= '0;
      r_last_sum   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_we0        <= 1'b0;
      r_we1        <= 1'b0;
      r_chan_enq   <= 1'b0;
      r_chan_deq   <= 1'b0;
      r_inflight   <= 1'b0;
      r_all_issued <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_chan_enq <= 1'b0;
      r_chan_deq <= 1'b0;
      r_we0      <= 1'b0;
      r_we1      <= 1'b0;
      r_inflight <= w_issue;
      if (w_fill_hs) begin
        r_fill_addr <= r_addr;
        r_fill_d    <= src_data;
        r_we0       <= !w_bank;
        r_we1       <= w_bank;
      end
      if (w_issue) begin
        r_all_issued <= r_rd_addr == LAST;
        if (r_rd_addr != LAST) r_rd_addr <= r_rd_addr + 1'b1;
      end
      case (r_state)
        S_IDLE:
          if (start) begin
            if (num_blocks == '0) r_done <= 1'b1;
            else begin
              r_busy  <= 1'b1;
              r_k     <= '0;
              r_nb    <= num_blocks;
              r_state <= S_FILL;
            end
          end
        S_FILL, S_FILL_NEXT:
          if (src_valid) begin
            r_addr <= r_addr == LAST ? '0 : r_addr + 1'b1;
            if (r_addr == LAST) r_state <= r_state == S_FILL ? S_SEND : S_WAIT_SUM;
          end
        S_SEND:
          if (!chan_full) begin
            r_chan_enq <= 1'b1;
            r_chan_d   <= W_D'(r_k);
            r_state    <= w_more ? S_FILL_NEXT : S_WAIT_SUM;
          end
        S_WAIT_SUM:
          if (!chan_empty) begin
            r_chan_deq <= 1'b1;
            r_last_sum <= chan_q;
            r_state    <= S_DRAIN;
          end
        S_DRAIN:
          if (w_pop) begin
            r_out_addr <= r_out_addr + 1'b1;
            if (r_out_addr == LAST) begin
              r_out_addr   <= '0;
              r_rd_addr    <= '0;
              r_all_issued <= 1'b0;
              r_k          <= r_k + 1'b1;
              r_state      <= w_more ? S_SEND : S_FINISH;
            end
          end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_doublebuffer_ctrl.sv
// tb_doublebuffer_ctrl: bank memories, user-logic stand-in and scoreboard around doublebuffer_ctrl
module tb_doublebuffer_ctrl;
  localparam int W_A = 3, W_D = 32, SIZE = 8, W_NB = 16;
  logic CLK = 0, RST_N = 0, start = 0;
  logic [W_NB-1:0] num_blocks = '0;
  logic busy, done, src_ready, fill_we0, fill_we1, dst_valid, chan_enq, chan_deq, chan_full;
  logic [W_D-1:0] last_sum, fill_d, dst_data, chan_d;
  logic [W_A-1:0] fill_addr, drain_addr;
  logic [W_D-1:0] src_data = '0, drain_q0 = '0, drain_q1 = '0, chan_q = '0;
  logic src_valid = 0, dst_ready = 1, chan_empty = 1;
  logic stall_f = 0, stall_e = 0, bp = 0;
  assign chan_full = stall_f;
  int checks = 0, errors = 0;
  logic [W_D-1:0] exp_q[$], src_q[$], sum_q[$];
  int tok_q[$];
  logic [W_D-1:0] rb[2][SIZE], wb[2][SIZE];
  logic [W_D-1:0] user_sum = '0, exp_last = '0, prev_data = '0;
  int fills, outs, srcs, enqs, deqs, dones, bp_i, run_nb;
  bit prev_stall, prev_full, prev_empty;

  doublebuffer_ctrl #(.W_A(W_A), .W_D(W_D), .SIZE(SIZE), .W_NB(W_NB)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .num_blocks(num_blocks), .busy(busy), .done(done),
    .last_sum(last_sum), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .fill_addr(fill_addr), .fill_d(fill_d), .fill_we0(fill_we0), .fill_we1(fill_we1),
    .drain_addr(drain_addr), .drain_q0(drain_q0), .drain_q1(drain_q1), .dst_data(dst_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .chan_d(chan_d), .chan_enq(chan_enq),
    .chan_full(chan_full), .chan_q(chan_q), .chan_deq(chan_deq), .chan_empty(chan_empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic nz;
    nz = |{busy, done, last_sum, src_ready, fill_addr, fill_d, fill_we0, fill_we1, drain_addr,
           dst_data, dst_valid, chan_d, chan_enq, chan_deq};
    chk(!nz, name, nz, 0);
  endtask

  // Bank memories (1-cycle read latency) and the user logic: per token, prefix-sum the read bank into the write bank.
  always @(posedge CLK) begin
    if (fill_we0) rb[0][fill_addr] = fill_d;
    if (fill_we1) rb[1][fill_addr] = fill_d;
    drain_q0 <= wb[0][drain_addr];
    drain_q1 <= wb[1][drain_addr];
    if (chan_deq && sum_q.size() > 0) void'(sum_q.pop_front());
    if (chan_enq) begin
      for (int a = 0; a < SIZE; a++) begin
        user_sum = user_sum + rb[chan_d[0]][a];
        wb[chan_d[0]][a] = user_sum;
      end
      sum_q.push_back(user_sum);
    end
    chan_empty <= sum_q.size() == 0 || stall_e;
    chan_q <= sum_q.size() > 0 ? sum_q[0] : '0;
  end

  always @(posedge CLK) begin
    if (src_valid && src_ready && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    src_valid = src_q.size() > 0 && $urandom_range(0, 3) != 0;
    src_data = src_q.size() > 0 ? src_q[0] : W_D'($urandom);
    bp_i++;
    dst_ready = !bp || (bp_i % 4 == 0) || (bp_i % 4 == 3);
  end

  always @(negedge CLK) begin : mon
    int t;
    if (!RST_N) begin
      prev_stall = 0;
      prev_full = 0;
      prev_empty = 0;
    end else begin
      if (fill_we0 || fill_we1) begin
        chk(!(fill_we0 && fill_we1), "we_exclusive", {fill_we0, fill_we1}, 1);
        fills++;
      end
      if (src_valid && src_ready) srcs++;
      if (chan_enq) begin
        chk(!prev_full, "enq_while_full", 1, 0);
        chk(outs == enqs * SIZE, "enq_before_drain", outs, enqs * SIZE);
        if (tok_q.size() == 0) chk(0, "extra_token", chan_d, -1);
        else begin
          t = tok_q.pop_front();
          chk(chan_d == W_D'(t), "token", chan_d, t);
        end
        enqs++;
      end
      if (chan_deq) begin
        t = (deqs + 2 < run_nb ? deqs + 2 : run_nb) * SIZE;
        chk(!prev_empty, "deq_while_empty", 1, 0);
        chk(fills == t, "fill_before_deq", fills, t);
        deqs++;
      end
      if (prev_stall) chk(dst_valid && dst_data == prev_data, "dst_hold", dst_data, prev_data);
      if (dst_valid && dst_ready) begin
        if (exp_q.size() == 0) chk(0, "dst_extra", dst_data, -1);
        else begin
          chk(dst_data == exp_q[0], "dst_data", dst_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        outs++;
      end
      if (done) dones++;
      prev_stall = dst_valid && !dst_ready;
      prev_data = dst_data;
      prev_full = chan_full;
      prev_empty = chan_empty;
    end
  end

  // Reference: outputs are the running sum of the whole run's input stream; tokens are 0..nb-1.
  task automatic begin_run(input int nb, input int pat);
    logic [W_D-1:0] s, w;
    s = '0;
    fills = 0; outs = 0; srcs = 0; enqs = 0; deqs = 0; dones = 0; run_nb = nb; user_sum = '0;
    for (int i = 0; i < nb * SIZE; i++) begin
      w = pat == 1 ? (i < SIZE ? W_D'(i + 1) : W_D'(1)) : W_D'($urandom_range(0, 1000));
      src_q.push_back(w);
      s = s + w;
      exp_q.push_back(s);
    end
    for (int k = 0; k < nb; k++) tok_q.push_back(k);
    exp_last = s;
    @(posedge CLK); #1;
    start = 1;
    num_blocks = W_NB'(nb);
    @(posedge CLK); #1;
    start = 0;
    @(negedge CLK);
    chk(busy == (nb != 0), "busy_after_start", busy, nb != 0);
    chk(done == (nb == 0), "done_after_start", done, nb == 0);
  endtask

  task automatic finish_run();
    int n;
    n = 0;
    while (dones == 0 && n < 4000) begin
      @(negedge CLK);
      n++;
    end
    chk(dones != 0, "done_timeout", n, 4000);
    repeat (3) @(negedge CLK);
    chk(dones == 1, "done_once", dones, 1);
    chk(!busy, "busy_cleared", busy, 0);
    chk(exp_q.size() == 0, "dst_missing", exp_q.size(), 0);
    chk(tok_q.size() == 0, "token_missing", tok_q.size(), 0);
    chk(srcs == run_nb * SIZE, "src_count", srcs, run_nb * SIZE);
    if (run_nb > 0) chk(last_sum == exp_last, "last_sum", last_sum, exp_last);
    exp_q.delete();
    tok_q.delete();
    src_q.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset_outputs");
    @(posedge CLK); #1;
    RST_N = 1;
    begin_run(1, 1); finish_run();
    begin_run(2, 1); finish_run();
    bp = 1;
    begin_run(3, 0); finish_run();
    bp = 0;
    stall_f = 1;
    stall_e = 1;
    begin_run(1, 0);
    n = 0;
    while (srcs < SIZE && n < 2000) begin @(negedge CLK); n++; end
    chk(srcs == SIZE, "fill_timeout", srcs, SIZE);
    repeat (20) @(posedge CLK);
    #1 stall_f = 0;
    n = 0;
    while (enqs == 0 && n < 2000) begin @(negedge CLK); n++; end
    chk(enqs == 1, "enq_timeout", enqs, 1);
    repeat (50) @(posedge CLK);
    #1 stall_e = 0;
    finish_run();
    begin_run(0, 0); finish_run();
    chk(enqs == 0, "zero_no_token", enqs, 0);
    bp = 1;
    begin_run(1, 0);
    n = 0;
    while (outs < 3 && n < 2000) begin @(negedge CLK); n++; end
    chk(outs >= 3, "drain_timeout", outs, 3);
    @(posedge CLK); #2;
    RST_N = 0;
    #1 chk_zero("reset_async");
    @(posedge CLK); #1;
    exp_q.delete(); tok_q.delete(); src_q.delete(); sum_q.delete();
    bp = 0;
    RST_N = 1;
    begin_run(1, 0); finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
